// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring, one bit per cycle; the unit raises stall on HI/LO hazards.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 opdiv;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   acc;

    logic                 known;
    logic                 accept;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     diff;
    logic [2*WIDTH-1:0]   accnext;
    logic [WIDTH-1:0]     remnext;

    // acc holds {partial product, multiplier} for multu and the dividend/quotient in its low half for divu.
    // The trial remainder is WIDTH+1 bits; the stored remainder always fits in WIDTH because it stays below the divisor.
    always_comb begin
        known = 1'b0;
        case (funct)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULTU, FN_DIVU: known = 1'b1;
            default: known = 1'b0;
        endcase
        accept = valid && known && (state != RUN);
        stall  = valid && known && (state == RUN);

        rd_data = '0;
        if (funct == FN_MFHI)
            rd_data = hi;
        else if (funct == FN_MFLO)
            rd_data = lo;

        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
        trial   = {rem, acc[WIDTH-1]};
        diff    = trial[WIDTH-1:0] - opb;
        accnext = acc;
        remnext = rem;
        if (opdiv) begin
            if (trial >= {1'b0, opb}) begin
                remnext = diff;
                accnext = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
            end else begin
                remnext = trial[WIDTH-1:0];
                accnext = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            accnext = {sum, acc[WIDTH-1:1]};
        end
    end

    // A division by zero needs no special case: every trial subtract succeeds, giving an all-ones quotient and remainder A.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            opdiv <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            rem   <= '0;
            acc   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (accept) begin
                        case (funct)
                            FN_MULTU, FN_DIVU: begin
                                state <= RUN;
                                busy  <= 1'b1;
                                opdiv <= (funct == FN_DIVU);
                                opa   <= rs_data;
                                opb   <= rt_data;
                                rem   <= '0;
                                acc   <= {{WIDTH{1'b0}}, (funct == FN_DIVU) ? rs_data : rt_data};
                                cnt   <= CNT_W'(WIDTH - 1);
                            end
                            FN_MTHI: hi <= rs_data;
                            FN_MTLO: lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc <= accnext;
                    rem <= remnext;
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (opdiv) begin
                            lo <= accnext[WIDTH-1:0];
                            hi <= remnext;
                        end else begin
                            hi <= accnext[2*WIDTH-1:WIDTH];
                            lo <= accnext[WIDTH-1:0];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance for the main sequence and an 8-bit instance for narrow-width checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic        valid;
    logic [5:0]  funct;
    logic [31:0] rs_data, rt_data, rd_data, hi, lo;
    logic        busy, done, stall;

    logic        valid8;
    logic [5:0]  funct8;
    logic [7:0]  rs8, rt8, rd8, hi8, lo8;
    logic        busy8, done8, stall8;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .valid(valid), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .rd_data(rd_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    muldiv_unit #(.WIDTH(8), .CNT_W(3)) dut8 (
        .clk(clk), .rst(rst), .valid(valid8), .funct(funct8),
        .rs_data(rs8), .rt_data(rt8), .rd_data(rd8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .stall(stall8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid   = v;
        funct   = f;
        rs_data = a;
        rt_data = b;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        valid8 = 1'b0; funct8 = 6'd0; rs8 = 8'd0; rt8 = 8'd0;
        step(); step();
        rst = 1'b0;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);

        // mthi / mtlo in IDLE, then mfhi / mflo reads
        applyStimulus(1'b1, 6'd17, 32'hDEADBEEF, 32'd0);
        #1 checkOutput("mthi_stall", 64'(stall), 64'd0);
        step();
        checkOutput("mthi_hi", 64'(hi), 64'hDEADBEEF);
        applyStimulus(1'b1, 6'd19, 32'h1, 32'd0);
        #1 checkOutput("mtlo_stall", 64'(stall), 64'd0);
        step();
        checkOutput("mtlo_lo", 64'(lo), 64'h1);
        checkOutput("mtlo_hi_kept", 64'(hi), 64'hDEADBEEF);
        applyStimulus(1'b1, 6'd16, 32'd0, 32'd0);
        #1 checkOutput("mfhi_rd", 64'(rd_data), 64'hDEADBEEF);
        applyStimulus(1'b1, 6'd18, 32'd0, 32'd0);
        #1 checkOutput("mflo_rd", 64'(rd_data), 64'h1);
        applyStimulus(1'b1, 6'd32, 32'd0, 32'd0);
        #1 checkOutput("other_rd", 64'(rd_data), 64'd0);

        // signed mult is unrecognised: no stall, no state change
        applyStimulus(1'b1, 6'd24, 32'd9, 32'd9);
        #1 checkOutput("f24_stall", 64'(stall), 64'd0);
        step();
        checkOutput("f24_busy", 64'(busy), 64'd0);
        checkOutput("f24_lo", 64'(lo), 64'h1);

        // multu all-ones latency
        applyStimulus(1'b1, 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        applyStimulus(1'b0, 6'd0, 32'h5A5A5A5A, 32'hA5A5A5A5);
        for (int i = 1; i <= 32; i++) begin
            checkOutput($sformatf("mul_busy_%0d", i), 64'(busy), 64'd1);
            checkOutput($sformatf("mul_done_%0d", i), 64'(done), 64'd0);
            step();
        end
        checkOutput("mul_done", 64'(done), 64'd1);
        checkOutput("mul_busy_end", 64'(busy), 64'd0);
        checkOutput("mul_hi", 64'(hi), 64'hFFFFFFFE);
        checkOutput("mul_lo", 64'(lo), 64'h00000001);
        step();
        checkOutput("mul_done_pulse", 64'(done), 64'd0);

        // divu 100/7, then divu by zero accepted in the DONE cycle
        applyStimulus(1'b1, 6'd27, 32'd100, 32'd7);
        step();
        applyStimulus(1'b0, 6'd0, 32'hFFFF0000, 32'd0);
        repeat (32) step();
        checkOutput("div_done", 64'(done), 64'd1);
        checkOutput("div_lo", 64'(lo), 64'd14);
        checkOutput("div_hi", 64'(hi), 64'd2);
        applyStimulus(1'b1, 6'd27, 32'h12345678, 32'd0);
        step();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        checkOutput("div0_busy", 64'(busy), 64'd1);
        repeat (31) step();
        checkOutput("div0_done_early", 64'(done), 64'd0);
        step();
        checkOutput("div0_done", 64'(done), 64'd1);
        checkOutput("div0_lo", 64'(lo), 64'hFFFFFFFF);
        checkOutput("div0_hi", 64'(hi), 64'h12345678);
        step();

        // hazard: mfhi during RUN stalls, reads new hi in DONE, back-to-back divu
        applyStimulus(1'b1, 6'd25, 32'h00010000, 32'h00010000);
        step();
        applyStimulus(1'b1, 6'd16, 32'd0, 32'd0);
        for (int i = 1; i <= 32; i++) begin
            checkOutput($sformatf("haz_stall_%0d", i), 64'(stall), 64'd1);
            checkOutput($sformatf("haz_hi_%0d", i), 64'(hi), 64'h12345678);
            step();
        end
        checkOutput("haz_done", 64'(done), 64'd1);
        checkOutput("haz_done_stall", 64'(stall), 64'd0);
        checkOutput("haz_done_rd", 64'(rd_data), 64'h1);
        checkOutput("haz_lo", 64'(lo), 64'h0);
        applyStimulus(1'b1, 6'd27, 32'd100, 32'd7);
        step();
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        applyStimulus(1'b0, 6'd0, 32'hCAFEF00D, 32'h3);
        repeat (32) step();
        checkOutput("b2b_done", 64'(done), 64'd1);
        checkOutput("b2b_lo", 64'(lo), 64'd14);
        checkOutput("b2b_hi", 64'(hi), 64'd2);
        step();

        // reset in the 10th RUN cycle of multu 3*5 aborts the write
        applyStimulus(1'b1, 6'd25, 32'd3, 32'd5);
        step();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        repeat (9) step();
        checkOutput("abort_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'd0);
        checkOutput("abort_lo", 64'(lo), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || lo !== 32'd0) begin
                checkOutput("abort_late_write", {31'd0, done, lo}, 64'd0);
                break;
            end
            step();
        end
        checkOutput("abort_lo_final", 64'(lo), 64'd0);

        // 8-bit instance: multu 0xFF*0xFF and unrecognised funct 24
        valid8 = 1'b1; funct8 = 6'd25; rs8 = 8'hFF; rt8 = 8'hFF;
        step();
        valid8 = 1'b0; funct8 = 6'd0; rs8 = 8'h00; rt8 = 8'h00;
        checkOutput("w8_busy", 64'(busy8), 64'd1);
        repeat (7) step();
        checkOutput("w8_done_early", 64'(done8), 64'd0);
        step();
        checkOutput("w8_done", 64'(done8), 64'd1);
        checkOutput("w8_hi", 64'(hi8), 64'hFE);
        checkOutput("w8_lo", 64'(lo8), 64'h01);
        step();
        valid8 = 1'b1; funct8 = 6'd24; rs8 = 8'h12; rt8 = 8'h34;
        #1 checkOutput("w8_f24_stall", 64'(stall8), 64'd0);
        step();
        valid8 = 1'b0;
        checkOutput("w8_f24_busy", 64'(busy8), 64'd0);
        checkOutput("w8_f24_hi", 64'(hi8), 64'hFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers, the sequential successor to the ALU control decoder. It decodes R-type funct codes for multu, divu, mfhi, mflo, mthi and mtlo, runs multiply and divide iteratively at one bit per cycle, and raises a stall request on any HI/LO hazard. It sits beside the main ALU in the EX stage and is parametrised in datapath width.

Parameters:
WIDTH, 32, operand/HI/LO width in bits; legal range 2 to 64.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
valid  input  1  funct/operands valid this cycle (R-type in EX)
funct  input  6  function code: 25 multu, 27 divu, 16 mfhi, 18 mflo, 17 mthi, 19 mtlo
rs_data  input  WIDTH  operand A: multiplicand/dividend/mthi/mtlo source
rt_data  input  WIDTH  operand B: multiplier/divisor
rd_data  output  WIDTH  combinational: hi if funct=mfhi, lo if funct=mflo, else 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  registered; 1 in RUN state
done  output  1  registered; 1-cycle pulse in DONE state
stall  output  1  combinational hazard/stall request to pipeline

Behaviour:
- Reset: when rst=1 at an edge, the state goes to IDLE; hi=0, lo=0, busy=0, done=0, and counter/working registers are cleared. Reset has priority over everything. Reset mid-operation aborts the operation; its result is never written.
- States: IDLE, RUN, DONE.
- Accept: a request is accepted when valid=1, funct is recognised, and state is IDLE or DONE. Unrecognised funct is ignored: no stall and no state change.
- multu/divu accept:
  - Latch rs_data and rt_data; load counter = WIDTH-1; go to RUN.
  - Multiply: shift-add with a 2*WIDTH accumulator.
  - Divide: restoring; remainder is WIDTH+1 bits wide.
- RUN: one iteration per cycle. When the iteration with counter=0 completes, write the results and go to DONE.
  - multu: {hi,lo} = A*B, full 2*WIDTH unsigned product.
  - divu: lo = A/B, hi = A%B, unsigned.
  - divu with B=0: same latency; lo = all ones, hi = A. No trap.
- DONE: done=1 for exactly one cycle, then return to IDLE. A new request may be accepted in this cycle and behaves as if issued from IDLE.
- Latency: for an accept at edge k, busy=1 for cycles k+1..k+WIDTH, hi/lo are updated at edge k+WIDTH, and done=1 during cycle k+WIDTH+1.
- mthi/mtlo: single cycle. On the accept edge, hi (or lo) = rs_data; state is unchanged; no busy or done.
- mfhi/mflo: rd_data reflects the current hi/lo combinationally.
- stall = valid & recognised funct & (state == RUN). This covers mfhi/mflo/mthi/mtlo/multu/divu while busy; such requests are not accepted and must be re-presented by the pipeline.
- In the DONE cycle, mfhi/mflo read the new results. mthi/mtlo in the DONE cycle overwrite the just-written value.
- Operands on rs_data/rt_data may change freely during RUN, since they were latched at accept.
- No signed operations: mult/div signed (funct 24/26) are treated as unrecognised.

Test Plan:
- WIDTH=32, multu A=B=0xFFFFFFFF accepted at edge k -> busy=1 for 32 cycles; at edge k+32 hi=0xFFFFFFFE, lo=0x00000001; done=1 only during cycle k+33.
- divu A=100, B=7 -> after 32 RUN cycles lo=14, hi=2; then divu A=0x12345678, B=0 -> lo=0xFFFFFFFF, hi=0x12345678, same latency.
- mthi rs=0xDEADBEEF, then mtlo rs=0x1 in IDLE -> hi/lo update on the accept edge with stall=0; mfhi and mflo give rd_data=0xDEADBEEF and 0x00000001.
- Issue multu, then mfhi on the next cycle -> stall=1 for each RUN cycle and hi unchanged; in the DONE cycle stall=0 and rd_data = new hi; a back-to-back divu in DONE is accepted with no idle gap.
- rst=1 in the 10th RUN cycle of multu 3*5 -> next cycle state IDLE, hi=lo=0, busy=done=0; no later write of 15.
- WIDTH=8, CNT_W=3: multu 0xFF*0xFF -> hi=0xFE, lo=0x01 after 8 RUN cycles; valid with funct=24 -> no stall, no state change.
